door_dir_decoder: RTL and testbench

- Generates the up/down pulses for the branch occupancy counter, sitting on the sensor side of that counter.
- Decodes two door light-beam sensors (outer, inner) into direction events. Complete entry sequence → one-cycle up pulse; complete exit sequence → one-cycle down pulse.
- Takes the counter's full_flag/empty_flag back to suppress impossible events and to drive a door-deny indicator.

---
 rtl/door_dir_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_door_dir_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/door_dir_decoder.sv
// Door light-beam direction decoder: entry → up pulse, exit → down pulse, guarded by counter full/empty.
// Latency raw->up/down: 2 sync + DEB_CYCLES + 1; no backpressure (single-cycle pulses, levels).
// `define DOOR_STATS_EN to add saturating entry/exit/abort totals.
module door_dir_decoder #(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clkup,
  input  logic       reset_n,
  input  logic       sens_out,
  input  logic       sens_in,
  input  logic       full_flag,
  input  logic       empty_flag,
  output logic       up,
  output logic       down,
  output logic       entry_deny,
  output logic       busy,
  output logic       err
`ifdef DOOR_STATS_EN
  ,
  output logic [7:0] entry_total,
  output logic [7:0] exit_total,
  output logic [7:0] abort_total
`endif
);

  localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] IN1  = 3'd1;
  localparam logic [2:0] IN2  = 3'd2;
  localparam logic [2:0] IN3  = 3'd3;
  localparam logic [2:0] OUT1 = 3'd4;
  localparam logic [2:0] OUT2 = 3'd5;
  localparam logic [2:0] OUT3 = 3'd6;
  localparam logic [2:0] ERRW = 3'd7;

  logic [1:0]  sync_o;
  logic [1:0]  sync_i;
  logic [7:0]  deb_cnt_o;
  logic [7:0]  deb_cnt_i;
  logic        filt_o;
  logic        filt_i;
  logic [1:0]  pair;
  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] to_cnt;
  logic        partial;
  logic        ev_up;
  logic        ev_down;
  logic        ev_err;

  // Filtered value flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clkup or negedge reset_n) begin
    if (!reset_n) begin
      sync_o    <= 2'b00;
      sync_i    <= 2'b00;
      deb_cnt_o <= 8'd0;
      deb_cnt_i <= 8'd0;
      filt_o    <= 1'b0;
      filt_i    <= 1'b0;
    end else begin
      sync_o <= {sync_o[0], sens_out};
      sync_i <= {sync_i[0], sens_in};

      if (sync_o[1] == filt_o) begin
        deb_cnt_o <= 8'd0;
      end else if (deb_cnt_o == DEB_LAST) begin
        filt_o    <= sync_o[1];
        deb_cnt_o <= 8'd0;
      end else begin
        deb_cnt_o <= deb_cnt_o + 8'd1;
      end

      if (sync_i[1] == filt_i) begin
        deb_cnt_i <= 8'd0;
      end else if (deb_cnt_i == DEB_LAST) begin
        filt_i    <= sync_i[1];
        deb_cnt_i <= 8'd0;
      end else begin
        deb_cnt_i <= deb_cnt_i + 8'd1;
      end
    end
  end

  assign pair    = {filt_o, filt_i};
  assign partial = (state != IDLE) && (state != ERRW);

  always_comb begin
    state_nxt = state;
    ev_up     = 1'b0;
    ev_down   = 1'b0;
    ev_err    = 1'b0;
    case (state)
      IDLE: begin
        case (pair)
          2'b10:   state_nxt = IN1;
          2'b01:   state_nxt = OUT1;
          2'b11: begin
            state_nxt = ERRW;
            ev_err    = 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end
      IN1: begin
        case (pair)
          2'b11:   state_nxt = IN2;
          2'b00:   state_nxt = IDLE;
          2'b01: begin
            state_nxt = ERRW;
            ev_err    = 1'b1;
          end
          default: state_nxt = IN1;
        endcase
      end
      IN2: begin
        case (pair)
          2'b01:   state_nxt = IN3;
          2'b10:   state_nxt = IN1;
          2'b00: begin
            state_nxt = ERRW;
            ev_err    = 1'b1;
          end
          default: state_nxt = IN2;
        endcase
      end
      IN3: begin
        case (pair)
          2'b00: begin
            state_nxt = IDLE;
            ev_up     = !full_flag;
            ev_err    = full_flag;
          end
          2'b11:   state_nxt = IN2;
          2'b10: begin
            state_nxt = ERRW;
            ev_err    = 1'b1;
          end
          default: state_nxt = IN3;
        endcase
      end
      OUT1: begin
        case (pair)
          2'b11:   state_nxt = OUT2;
          2'b00:   state_nxt = IDLE;
          2'b10: begin
            state_nxt = ERRW;
            ev_err    = 1'b1;
          end
          default: state_nxt = OUT1;
        endcase
      end
      OUT2: begin
        case (pair)
          2'b10:   state_nxt = OUT3;
          2'b01:   state_nxt = OUT1;
          2'b00: begin
            state_nxt = ERRW;
            ev_err    = 1'b1;
          end
          default: state_nxt = OUT2;
        endcase
      end
      OUT3: begin
        case (pair)
          2'b00: begin
            state_nxt = IDLE;
            ev_down   = !empty_flag;
            ev_err    = empty_flag;
          end
          2'b11:   state_nxt = OUT2;
          2'b01: begin
            state_nxt = ERRW;
            ev_err    = 1'b1;
          end
          default: state_nxt = OUT3;
        endcase
      end
      default: begin
        if (pair == 2'b00) state_nxt = IDLE;
      end
    endcase

    // Every filtered change in a partial state moves the FSM, so "no move" means "no change".
    if (partial && (state_nxt == state) && (to_cnt == TO_LAST)) begin
      state_nxt = ERRW;
      ev_err    = 1'b1;
    end
  end

  always_ff @(posedge clkup or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      to_cnt     <= 16'd0;
      up         <= 1'b0;
      down       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      entry_deny <= 1'b0;
    end else begin
      state      <= state_nxt;
      to_cnt     <= (partial && (state_nxt == state)) ? to_cnt + 16'd1 : 16'd0;
      up         <= ev_up;
      down       <= ev_down;
      err        <= ev_err;
      busy       <= (state_nxt != IDLE);
      entry_deny <= ((state_nxt == IN1) || (state_nxt == IN2) || (state_nxt == IN3)) && full_flag;
    end
  end

`ifdef DOOR_STATS_EN
  always_ff @(posedge clkup or negedge reset_n) begin
    if (!reset_n) begin
      entry_total <= 8'd0;
      exit_total  <= 8'd0;
      abort_total <= 8'd0;
    end else begin
      if (ev_up && (entry_total != 8'hFF))  entry_total <= entry_total + 8'd1;
      if (ev_down && (exit_total != 8'hFF)) exit_total  <= exit_total + 8'd1;
      if (ev_err && (abort_total != 8'hFF)) abort_total <= abort_total + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_door_dir_decoder.sv
// Randomized bench for door_dir_decoder; reference model walks the beam ring 00-10-11-01 per sequence.
module tb_door_dir_decoder;

  localparam int DEB = 4;
  localparam int TO  = 64;
  localparam int LAT = DEB + 2;

  logic clkup = 1'b0;
  logic reset_n = 1'b1;
  logic sens_out = 1'b0;
  logic sens_in = 1'b0;
  logic full_flag = 1'b0;
  logic empty_flag = 1'b0;
  logic up, down, entry_deny, busy, err;
`ifdef DOOR_STATS_EN
  logic [7:0] entry_total, exit_total, abort_total;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state: 0 idle, 1 walking the ring, 2 waiting for 00
  int m_st, m_dir, m_steps, m_tcnt;
  logic [1:0] m_prev;
  logic [1:0] hist [0:LAT];
  bit exp_up, exp_down, exp_err, exp_busy, exp_deny;
  int exp_ent, exp_ext, exp_abt;

  door_dir_decoder #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clkup(clkup), .reset_n(reset_n), .sens_out(sens_out), .sens_in(sens_in),
    .full_flag(full_flag), .empty_flag(empty_flag), .up(up), .down(down),
    .entry_deny(entry_deny), .busy(busy), .err(err)
`ifdef DOOR_STATS_EN
    , .entry_total(entry_total), .exit_total(exit_total), .abort_total(abort_total)
`endif
  );

  always #5 clkup = ~clkup;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ring_pos(input logic [1:0] p);
    case (p)
      2'b10:   return 1;
      2'b11:   return 2;
      2'b01:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_dir = 0; m_steps = 0; m_tcnt = 0; m_prev = 2'b00;
    for (int k = 0; k <= LAT; k++) hist[k] = 2'b00;
    exp_up = 0; exp_down = 0; exp_err = 0; exp_busy = 0; exp_deny = 0;
    exp_ent = 0; exp_ext = 0; exp_abt = 0;
  endtask

  // Predicts outputs after the next rising edge, given the filtered pair the FSM sees there.
  task automatic model_edge(input logic [1:0] p);
    int pos, ppos, delta;
    pos = ring_pos(p);
    ppos = ring_pos(m_prev);
    exp_up = 0; exp_down = 0; exp_err = 0;
    case (m_st)
      0: begin
        if (pos == 1 || pos == 3) begin
          m_st = 1; m_dir = pos; m_steps = 1; m_tcnt = 0;
        end else if (pos == 2) begin
          m_st = 2; exp_err = 1;
        end
      end
      1: begin
        if (pos != ppos) begin
          delta = (pos - ppos + 4) % 4;
          m_tcnt = 0;
          if (delta == m_dir) begin
            m_steps++;
            if (m_steps == 4) begin
              m_st = 0;
              if (m_dir == 1) begin
                if (full_flag) exp_err = 1; else exp_up = 1;
              end else begin
                if (empty_flag) exp_err = 1; else exp_down = 1;
              end
            end
          end else if (delta == 4 - m_dir) begin
            m_steps--;
            if (m_steps == 0) m_st = 0;
          end else begin
            m_st = 2; exp_err = 1;
          end
        end else begin
          m_tcnt++;
          if (m_tcnt == TO) begin
            m_st = 2; exp_err = 1;
          end
        end
      end
      default: if (pos == 0) m_st = 0;
    endcase
    m_prev = p;
    exp_busy = (m_st != 0);
    exp_deny = (m_st == 1) && (m_dir == 1) && full_flag;
    if (exp_up) exp_ent = sat_inc(exp_ent);
    if (exp_down) exp_ext = sat_inc(exp_ext);
    if (exp_err) exp_abt = sat_inc(exp_abt);
  endtask

  task automatic compare_outputs();
    check_val("up", 32'(up), 32'(exp_up));
    check_val("down", 32'(down), 32'(exp_down));
    check_val("err", 32'(err), 32'(exp_err));
    check_val("busy", 32'(busy), 32'(exp_busy));
    check_val("entry_deny", 32'(entry_deny), 32'(exp_deny));
`ifdef DOOR_STATS_EN
    check_val("entry_total", 32'(entry_total), 32'(exp_ent));
    check_val("exit_total", 32'(exit_total), 32'(exp_ext));
    check_val("abort_total", 32'(abort_total), 32'(exp_abt));
`endif
  endtask

  task automatic step(input logic ro, input logic ri, input logic [1:0] clean,
                      input logic ff, input logic ef);
    @(negedge clkup);
    compare_outputs();
    sens_out = ro; sens_in = ri; full_flag = ff; empty_flag = ef;
    for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = clean;
    model_edge(hist[LAT]);
  endtask

  // Glitches are 2-cycle flips placed well inside a phase of at least 12 cycles.
  task automatic phase(input logic [1:0] p, input int len, input bit gl_o, input bit gl_i,
                       input logic ff, input logic ef);
    for (int k = 0; k < len; k++) begin
      logic ro, ri;
      ro = p[1];
      ri = p[0];
      if (gl_o && len >= 12 && (k == 7 || k == 8)) ro = ~ro;
      if (gl_i && len >= 12 && (k == 7 || k == 8)) ri = ~ri;
      step(ro, ri, p, ff, ef);
    end
  endtask

  task automatic seq4(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                      input int len, input bit gl, input logic ff, input logic ef);
    phase(a, len, gl, 1'b0, ff, ef);
    phase(b, len, gl, 1'b0, ff, ef);
    phase(c, len, gl, 1'b0, ff, ef);
    phase(2'b00, len, gl, 1'b0, ff, ef);
  endtask

  task automatic do_reset(input bit mid);
    if (mid) begin
      @(posedge clkup);
      #2;
    end
    reset_n = 1'b0;
    sens_out = 1'b0; sens_in = 1'b0; full_flag = 1'b0; empty_flag = 1'b0;
    #1;
    check_val("rst_up", 32'(up), 32'd0);
    check_val("rst_down", 32'(down), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_deny", 32'(entry_deny), 32'd0);
`ifdef DOOR_STATS_EN
    check_val("rst_entry_total", 32'(entry_total), 32'd0);
`endif
    repeat (3) @(negedge clkup);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #1;
    do_reset(1'b0);
    phase(2'b00, 8, 0, 0, 0, 0);

    // entry, then exits with and without empty, with glitches
    seq4(2'b10, 2'b11, 2'b01, 10, 0, 0, 0);
    phase(2'b00, 10, 0, 0, 0, 0);
    seq4(2'b01, 2'b11, 2'b10, 10, 0, 0, 0);
    seq4(2'b01, 2'b11, 2'b10, 10, 0, 0, 1);
    seq4(2'b01, 2'b11, 2'b10, 12, 1, 0, 0);
    seq4(2'b01, 2'b11, 2'b10, 12, 1, 0, 1);
    phase(2'b00, 10, 0, 0, 0, 0);

    // back-out and illegal 00->11
    phase(2'b10, 10, 0, 0, 0, 0);
    phase(2'b00, 10, 0, 0, 0, 0);
    phase(2'b11, 20, 0, 0, 0, 0);
    phase(2'b00, 10, 0, 0, 0, 0);

    // full counter blocks entry; timeout in IN1
    seq4(2'b10, 2'b11, 2'b01, 10, 0, 1, 0);
    phase(2'b10, 80, 0, 0, 0, 0);
    phase(2'b00, 10, 0, 0, 0, 0);

    // async reset while in IN3
    phase(2'b10, 10, 0, 0, 0, 0);
    phase(2'b11, 10, 0, 0, 0, 0);
    phase(2'b01, 9, 0, 0, 0, 0);
    check_val("in3_busy", 32'(busy), 32'd1);
    do_reset(1'b1);
    phase(2'b00, 15, 0, 0, 0, 0);

    // random phases, occasional long holds for timeouts
    for (int n = 0; n < 120; n++) begin
      logic [1:0] p;
      int len;
      p = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 9) == 0) ? 80 : int'($urandom_range(12, 20));
      phase(p, len, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    phase(2'b00, 15, 0, 0, 0, 0);

`ifdef DOOR_STATS_EN
    do_reset(1'b0);
    for (int n = 0; n < 3; n++) seq4(2'b10, 2'b11, 2'b01, 10, 0, 0, 0);
    for (int n = 0; n < 2; n++) seq4(2'b01, 2'b11, 2'b10, 10, 0, 0, 0);
    phase(2'b10, 80, 0, 0, 0, 0);
    phase(2'b00, 10, 0, 0, 0, 0);
    check_val("stat_entries", 32'(entry_total), 32'd3);
    check_val("stat_exits", 32'(exit_total), 32'd2);
    check_val("stat_aborts", 32'(abort_total), 32'd1);
    for (int n = 0; n < 300; n++) seq4(2'b10, 2'b11, 2'b01, 8, 0, 0, 0);
    phase(2'b00, 10, 0, 0, 0, 0);
    check_val("stat_entry_sat", 32'(entry_total), 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
